// File: rtl/ff_array_flush_scanner.sv
// Flush scanner: walks the dirty-bit array, writes back and clears each dirty set, then pulses flush_done.
// Latency: 1 cycle per clean set, 2 + ack-wait cycles per dirty set, plus 1 DONE cycle.
// Backpressure: holds wb_req and wb_set stable until wb_ack; no timeout, and flush_req is ignored while busy.
module ff_array_flush_scanner #(
    parameter int s_index = 4
) (
    input  logic               clk0,
    input  logic               rst0_n,
    input  logic               flush_req,
    output logic               busy,
    output logic               flush_done,
    output logic               arr_csb0,
    output logic               arr_web0,
    output logic [s_index-1:0] arr_addr0,
    output logic               arr_din0,
    input  logic               arr_dout0,
    output logic               wb_req,
    output logic [s_index-1:0] wb_set,
    input  logic               wb_ack
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WB,
        ST_CLEAR,
        ST_DONE
    } state_t;

    localparam logic [s_index-1:0] LAST_IDX = {s_index{1'b1}};

    state_t             state_q, state_d;
    logic [s_index-1:0] idx_q, idx_d;

    always_ff @(posedge clk0) begin
        if (!rst0_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                if (arr_dout0) begin
                    state_d = ST_WB;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_WB: begin
                if (wb_ack) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // The last set leaves straight for DONE so idx never wraps.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                    idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs depend only on state_q/idx_q; no input reaches an output combinationally.
    always_comb begin
        busy       = 1'b0;
        flush_done = 1'b0;
        arr_csb0   = 1'b1;
        arr_web0   = 1'b1;
        arr_addr0  = idx_q;
        arr_din0   = 1'b0;
        wb_req     = 1'b0;
        wb_set     = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                arr_addr0 = '0;
                wb_set    = '0;
            end
            ST_SCAN: begin
                busy     = 1'b1;
                arr_csb0 = 1'b0;
            end
            ST_WB: begin
                busy   = 1'b1;
                wb_req = 1'b1;
            end
            ST_CLEAR: begin
                busy     = 1'b1;
                arr_csb0 = 1'b0;
                arr_web0 = 1'b0;
            end
            ST_DONE: begin
                flush_done = 1'b1;
            end
            default: begin
                arr_addr0 = '0;
                wb_set    = '0;
            end
        endcase
    end

endmodule
